fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the instruction address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the instruction word width.
REQ-003 Parameter TMO_CYC, default 15, SHALL set the maximum number of cycles spent in REQ without MEM_ACK.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 REST  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 START  input  1  SHALL, while high, permit continuous fetching.
REQ-007 FLUSH  input  1  SHALL be a one-cycle abort, asserted together with the program counter's LOAD on a branch.
REQ-008 PC_IN  input  ADDR_W  SHALL carry the current program-counter value.
REQ-009 PC_INC  output  1  SHALL drive the program counter's EN.
REQ-010 MEM_ADDR  output  ADDR_W  SHALL be the registered memory read address.
REQ-011 MEM_RD  output  1  SHALL be the memory read request.
REQ-012 MEM_ACK  input  1  SHALL indicate that MEM_DATA is valid this cycle.
REQ-013 MEM_DATA  input  DATA_W  SHALL carry the memory read data.
REQ-014 IR_OUT  output  DATA_W  SHALL carry the fetched instruction (instruction register).
REQ-015 IR_VALID  output  1  SHALL indicate that IR_OUT holds an untransferred instruction.
REQ-016 DEC_READY  input  1  SHALL indicate that the decoder accepts IR_OUT; a transfer occurs on IR_VALID and DEC_READY both high.
REQ-017 ERR  output  1  SHALL be the sticky fetch-timeout flag.

Function
REQ-018 States SHALL be IDLE, REQ and HOLD, with a 2-bit encoding.
REQ-019 IDLE: on START=1, ERR=0 and FLUSH=0, the unit SHALL latch PC_IN into MEM_ADDR and enter REQ on the next edge.
REQ-020 REQ: MEM_RD SHALL be 1 and MEM_ADDR SHALL be held stable until exit from REQ.
REQ-021 REQ with MEM_ACK=1 and FLUSH=0: the unit SHALL latch MEM_DATA into IR_OUT, clear the timeout counter and enter HOLD.
REQ-022 PC_INC SHALL be combinational, (state==REQ) and MEM_ACK and not FLUSH, so the program counter increments on the same edge that IR_OUT is latched.
REQ-023 Fetch latency SHALL be 1 cycle from the MEM_ACK edge to IR_VALID=1.
REQ-024 HOLD: IR_VALID SHALL be 1 and IR_OUT SHALL be stable until transfer.
REQ-025 HOLD on transfer with START=1: the unit SHALL latch PC_IN (already incremented) into MEM_ADDR and enter REQ, giving back-to-back fetches.
REQ-026 HOLD on transfer with START=0: the unit SHALL enter IDLE.
REQ-027 In REQ, a counter SHALL increment each cycle without MEM_ACK.
REQ-028 On the cycle the counter reaches TMO_CYC-1 without MEM_ACK, the unit SHALL set ERR, drop MEM_RD at the next edge and enter IDLE.
REQ-029 While ERR=1, START SHALL be ignored.
REQ-030 The counter width SHALL be clog2(TMO_CYC)+1 bits, and it SHALL saturate and never wrap.
REQ-031 FLUSH=1 in any state: next state SHALL be IDLE and IR_VALID and MEM_RD SHALL be 0 after the edge.
REQ-032 FLUSH=1 in any state: IR_OUT SHALL be retained and the counter cleared.
REQ-033 FLUSH and MEM_ACK in the same cycle: FLUSH SHALL win; no IR latch and no PC_INC.
REQ-034 FLUSH and transfer in the same cycle: the transfer SHALL count for the decoder, and the unit SHALL still enter IDLE.
REQ-035 After a flush with START=1: one IDLE cycle, then REQ with the loaded PC_IN.
REQ-036 MEM_ACK outside REQ SHALL be ignored, including a late acknowledge after timeout.
REQ-037 START deasserted during REQ SHALL NOT abort the pending read; the unit completes into HOLD.
REQ-038 At most one read SHALL be outstanding.
REQ-039 MEM_ADDR SHALL be a pure latch of PC_IN with no arithmetic; PC_IN wrap-around from 0xFFF to 0x000 SHALL pass through unchanged.

Reset
REQ-040 REST=1 at a rising edge SHALL force state IDLE and MEM_ADDR=0, IR_OUT=0, IR_VALID=0, MEM_RD=0, ERR=0, with the counter cleared.
REQ-041 REST SHALL override FLUSH, MEM_ACK and START.
REQ-042 REST mid-REQ SHALL drop MEM_RD; the acknowledge for that read SHALL be ignored.
REQ-043 ERR SHALL be cleared only by REST.
REQ-044 PC_INC SHALL be 0 during a REST cycle.

Structure
REQ-045 A shared header fetch_defs SHALL hold the state encodings (IDLE=0, REQ=1, HOLD=2) and the default widths and TMO_CYC.
REQ-046 One sub-module, fetch_tmo_cnt, SHALL implement the saturating timeout counter with clear, enable and expired.
REQ-047 All other logic SHALL reside in fetch_unit.

Verification
REQ-048 Reset, START=1, PC_IN=0x010, memory acks 2 cycles after MEM_RD with 0x7A5C, DEC_READY=1 -> MEM_ADDR=0x010, one PC_INC pulse, IR_OUT=0x7A5C with IR_VALID 1 cycle after the ack, next MEM_ADDR=0x011.
REQ-049 DEC_READY=0 for 4 cycles in HOLD -> IR_VALID and IR_OUT stable, MEM_RD=0, no second PC_INC.
REQ-050 FLUSH and MEM_ACK in the same REQ cycle, with PC loaded to 0x200 -> no PC_INC, IR_OUT unchanged, IDLE, then MEM_ADDR=0x200.
REQ-051 No MEM_ACK for 15 cycles -> ERR=1, MEM_RD=0, and a late ack at cycle 17 is ignored; START ignored until REST.
REQ-052 PC_IN=0xFFF fetch with immediate acks -> MEM_ADDR 0xFFF then 0x000.
REQ-053 REST asserted in the second REQ cycle -> all outputs 0 next cycle, and an ack on the following cycle is ignored.

Source files
------------

// File: rtl/fetch_defs.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package   : fetch_defs                                                |
// | Purpose   : Shared state encodings, default widths and timeout length |
// |             for the instruction fetch unit.                           |
// | Revision  : 1.0  initial release                                      |
// +-----------------------------------------------------------------------+
package fetch_defs;

    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TMO_CYC = 15;

    // Fetch sequencer states; the numeric values are part of the interface.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    // Width of the timeout counter: one spare bit above clog2 so the
    // terminal value always fits and saturation is unambiguous.
    function automatic int tmo_cnt_width(input int tmo_cyc);
        return $clog2(tmo_cyc) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_tmo_cnt.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module    : fetch_tmo_cnt                                             |
// | Purpose   : Saturating wait counter for an outstanding memory read.   |
// |             Counts enabled cycles, flags the last permitted cycle.    |
// | Revision  : 1.0  initial release                                      |
// +-----------------------------------------------------------------------+
module fetch_tmo_cnt
    import fetch_defs::*;
#(
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int              CNT_W = tmo_cnt_width(TMO_CYC);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TMO_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority; increment stops at LIMIT (no wrap).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High during the final cycle a read may wait without acknowledge.
    assign expired = (cnt_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module    : fetch_unit                                                |
// | Purpose   : Single-outstanding instruction fetch sequencer feeding an |
// |             instruction register, with flush and sticky timeout.      |
// | Revision  : 1.0  initial release                                      |
// +-----------------------------------------------------------------------+
module fetch_unit
    import fetch_defs::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic              clk,
    input  logic              REST,
    input  logic              START,
    input  logic              FLUSH,
    input  logic [ADDR_W-1:0] PC_IN,
    output logic              PC_INC,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_RD,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic [DATA_W-1:0] IR_OUT,
    output logic              IR_VALID,
    input  logic              DEC_READY,
    output logic              ERR
);

    fetch_state_e      state_q,    state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q,   mem_rd_d;
    logic [DATA_W-1:0] ir_out_q,   ir_out_d;
    logic              ir_valid_q, ir_valid_d;
    logic              err_q,      err_d;

    logic in_req;
    logic transfer;
    logic tmo_en;
    logic tmo_clr;
    logic tmo_expired;

    assign in_req   = (state_q == ST_REQ);
    assign transfer = ir_valid_q && DEC_READY;

    // The wait counter runs only while a read is pending and unanswered;
    // any exit path from REQ (ack, flush, timeout) leaves it cleared.
    assign tmo_en  = in_req && !MEM_ACK;
    assign tmo_clr = FLUSH || MEM_ACK || !in_req;

    fetch_tmo_cnt #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo_cnt (
        .clk     (clk),
        .rst     (REST),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // Next-state and register-input logic for the fetch sequencer.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        ir_out_d   = ir_out_q;
        err_d      = err_q;

        unique case (state_q)
            ST_IDLE: begin
                // A timed-out unit stays parked until reset.
                if (START && !err_q && !FLUSH) begin
                    mem_addr_d = PC_IN;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                // Flush beats a same-cycle acknowledge: the data is dropped.
                if (FLUSH) begin
                    state_d = ST_IDLE;
                end else if (MEM_ACK) begin
                    ir_out_d = MEM_DATA;
                    state_d  = ST_HOLD;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // PC_IN has already advanced on the acknowledge edge, so it
                // is the address of the next sequential instruction here.
                if (FLUSH) begin
                    state_d = ST_IDLE;
                end else if (transfer) begin
                    if (START) begin
                        mem_addr_d = PC_IN;
                        state_d    = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Read request and valid flag are registered images of the state.
        mem_rd_d   = (state_d == ST_REQ);
        ir_valid_d = (state_d == ST_HOLD);
    end

    // Sequencer registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (REST) begin
            state_q    <= ST_IDLE;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            ir_out_q   <= '0;
            ir_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            ir_out_q   <= ir_out_d;
            ir_valid_q <= ir_valid_d;
            err_q      <= err_d;
        end
    end

    // Program counter advances on the same edge that captures the word.
    assign PC_INC   = in_req && MEM_ACK && !FLUSH && !REST;
    assign MEM_ADDR = mem_addr_q;
    assign MEM_RD   = mem_rd_q;
    assign IR_OUT   = ir_out_q;
    assign IR_VALID = ir_valid_q;
    assign ERR      = err_q;

endmodule
`default_nettype wire
